// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with a shared prescaler and period counter,
// double-buffered per-channel duty, edge- or center-aligned counting.
module pwm_multi_channel #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int PRESC_W = 8,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic [CNT_W-1:0]   i_period,
  input  logic               i_mode,
  input  logic               i_wr_en,
  input  logic [CH_W-1:0]    i_wr_ch,
  input  logic [CNT_W-1:0]   i_wr_duty,
  input  logic [NUM_CH-1:0]  i_ch_en,
  input  logic [NUM_CH-1:0]  i_invert,
  output logic [NUM_CH-1:0]  o_pwm,
  output logic               o_period_tick,
  output logic [NUM_CH-1:0]  o_pending
);

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  logic [PRESC_W-1:0] psc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_q;
  logic               mode_q;
  dir_t               dir;
  logic [CNT_W-1:0]   shadow [NUM_CH];
  logic [CNT_W-1:0]   active [NUM_CH];

  logic               tick;
  logic               bnd;
  logic [CNT_W-1:0]   cnt_nxt;
  dir_t               dir_nxt;
  logic [NUM_CH-1:0]  raw;
  logic               wr_ok;

  assign wr_ok = i_wr_en && (int'(i_wr_ch) < NUM_CH);

  // NOTE: every signal gets a default before any branch, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    tick    = i_en && (psc == i_prescale);
    cnt_nxt = cnt;
    dir_nxt = dir;
    bnd     = 1'b0;
    if (tick) begin
      if (period_q == '0) begin
        cnt_nxt = '0;
        dir_nxt = UP;
        bnd     = 1'b1;
      end else if (!mode_q) begin
        if (cnt >= period_q) begin
          cnt_nxt = '0;
          bnd     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (dir == UP) begin
        if (cnt >= period_q) begin
          cnt_nxt = period_q - 1'b1;
          dir_nxt = DOWN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else if (cnt == '0) begin
        // Valley of a center-aligned period: turn around and mark the boundary.
        cnt_nxt = CNT_W'(1);
        dir_nxt = UP;
        bnd     = 1'b1;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
      if (bnd && (i_mode != mode_q)) begin
        cnt_nxt = '0;
        dir_nxt = UP;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      raw[k] = i_ch_en[k] & (cnt < active[k]);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; a later assignment in the same block overrides an earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc           <= '0;
      cnt           <= '0;
      dir           <= UP;
      period_q      <= '0;
      mode_q        <= 1'b0;
      o_pending     <= '0;
      o_pwm         <= '0;
      o_period_tick <= 1'b0;
      // NOTE: the duty arrays are small register files, not RAM, so they are
      // reset explicitly to keep every channel at a known duty of zero.
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else if (!i_en) begin
      psc           <= '0;
      cnt           <= '0;
      dir           <= UP;
      period_q      <= i_period;
      mode_q        <= i_mode;
      o_pending     <= '0;
      o_pwm         <= i_invert;
      o_period_tick <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        active[k] <= shadow[k];
      end
      if (wr_ok) shadow[i_wr_ch] <= i_wr_duty;
    end else begin
      psc           <= (psc >= i_prescale) ? '0 : psc + 1'b1;
      cnt           <= cnt_nxt;
      dir           <= dir_nxt;
      o_period_tick <= bnd;
      o_pwm         <= raw ^ i_invert;
      if (bnd) begin
        period_q  <= i_period;
        mode_q    <= i_mode;
        o_pending <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          active[k] <= shadow[k];
        end
      end
      // A write on a boundary cycle lands in the shadow and stays pending.
      if (wr_ok) begin
        shadow[i_wr_ch]    <= i_wr_duty;
        o_pending[i_wr_ch] <= 1'b1;
      end
    end
  end

endmodule
